timestamp_arbiter: RTL and testbench
====================================

// Module: timestamp_arbiter
// PURPOSE
//  Shares the single 24-bit mission timestamp (output of the CLK_10HZ timestamp counter) among up to
//  NREQ packet builders (GPS, pressure, IMU, telemetry). Round-robin arbitration, one request served at a time.
//  TIMESTAMP is sampled twice and delivered only when both samples agree, so the 10 Hz counter is never torn.
//  Sits between the timestamp block and the packet formatters on the system clock.
// PARAMETERS
//  NREQ       4   number of requesters (2..8)
//  TS_WIDTH   24  timestamp width, matches the timestamp block output
//  MAX_RETRY  7   resample attempts before forced delivery (1..15)
// PORTS
//  CLK           in   1         system clock
//  RESET         in   1         synchronous, active-high reset
//  TIMESTAMP     in   TS_WIDTH  timestamp from CLK_10HZ domain, quasi-static
//  REQ           in   NREQ      level request per builder, held until its GRANT bit pulses
//  GRANT         out  NREQ      one-hot, one-cycle pulse, coincident with TS_VALID
//  TS_OUT        out  TS_WIDTH  delivered timestamp, holds until the next delivery
//  TS_VALID      out  1         one-cycle strobe: TS_OUT/TS_SRC valid
//  TS_SRC        out  3         index of the served requester
//  BUSY          out  1         high in every state except IDLE
//  ERR_UNSTABLE  out  1         sticky: a delivery was forced after MAX_RETRY
// BEHAVIOUR
//  Reset values: GRANT=0, TS_OUT=0, TS_VALID=0, TS_SRC=0, BUSY=0, ERR_UNSTABLE=0, state=IDLE,
//   retry=0, rr_ptr=NREQ-1 (REQ[0] has highest priority first).
//  States: IDLE -> SMP_A -> SMP_B -> CMP -> IDLE.
//   IDLE : if |REQ, idx <= first set bit searching rr_ptr+1 upward, modulo NREQ; go to SMP_A. Else stay.
//   SMP_A: s0 <= TIMESTAMP; go to SMP_B.
//   SMP_B: s1 <= TIMESTAMP; go to CMP.
//   CMP  : if s0==s1: deliver s1. Else if retry<MAX_RETRY: retry++, go to SMP_A.
//          Else: deliver s1 and set ERR_UNSTABLE.
//   Deliver (registered, from CMP): TS_OUT<=s1, TS_VALID<=1, TS_SRC<=idx, GRANT<=1<<idx,
//    rr_ptr<=idx, retry<=0, go to IDLE.
//  Latency: REQ seen in IDLE at edge k -> TS_VALID/GRANT high in the cycle after edge k+3 (clean case).
//   Each retry adds 3 cycles.
//  Throughput: a held REQ is re-evaluated in IDLE on the edge after delivery; minimum service period 4 cycles.
//  TS_VALID and GRANT are exactly one cycle wide; outputs are never combinational from REQ.
//  REQ dropped after IDLE has selected idx: delivery still completes and GRANT still pulses; the requester ignores it.
//  REQ bits outside the selected idx have no effect until the next IDLE.
//  Simultaneous requests: strict round-robin; a requester waits at most NREQ-1 deliveries.
//  ERR_UNSTABLE: cleared only by RESET; it does not block further operation.
//  RESET in any state: IDLE on the next edge, all reset values restored, in-flight request dropped,
//   no TS_VALID is emitted.
//  TIMESTAMP wrap (0xFFFFFF->0x000000) is an ordinary change: resampled like any other edge.
//  TS_SRC width covers NREQ<=8; unused upper bits are 0.
// TESTING
//  1 RESET held 2 cycles, REQ=4'b1111 -> all outputs 0, BUSY=0, no GRANT while RESET=1.
//  2 TIMESTAMP=24'h001234 stable, REQ[2] raised alone -> 4 cycles later TS_VALID=1, TS_OUT=24'h001234,
//    TS_SRC=2, GRANT=4'b0100 for 1 cycle.
//  3 REQ=4'b1111 held -> GRANT order 0001,0010,0100,1000,0001, with TS_VALID pulses 4 cycles apart.
//  4 TIMESTAMP 24'h0000FF->24'h000100 between SMP_A and SMP_B -> one retry, TS_OUT=24'h000100,
//    latency 7 cycles, ERR_UNSTABLE=0.
//  5 TIMESTAMP toggled every cycle, REQ[1] -> after 7 retries TS_OUT=last s1 and ERR_UNSTABLE=1;
//    it stays 1 through later clean deliveries until RESET.
//  6 RESET asserted in SMP_B with REQ[3] pending -> IDLE next edge, no TS_VALID; after release with
//    REQ=4'b1001, REQ[0] is served first.

Source files
------------

// File: rtl/timestamp_arbiter.sv
// rtl/timestamp_arbiter.sv - round-robin shared timestamp server with double-sample tear protection
module timestamp_arbiter #(
    parameter int NREQ      = 4,
    parameter int TS_WIDTH  = 24,
    parameter int MAX_RETRY = 7
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [TS_WIDTH-1:0] TIMESTAMP,
    input  logic [NREQ-1:0]     REQ,
    output logic [NREQ-1:0]     GRANT,
    output logic [TS_WIDTH-1:0] TS_OUT,
    output logic                TS_VALID,
    output logic [2:0]          TS_SRC,
    output logic                BUSY,
    output logic                ERR_UNSTABLE
);

    typedef enum logic [1:0] {IDLE, SMP_A, SMP_B, CMP} state_t;

    state_t              state;
    state_t              next_state;
    logic [2:0]          idx;
    logic [2:0]          rr_ptr;
    logic [2:0]          pick;
    logic [2:0]          cand;
    logic                pick_found;
    logic [3:0]          retry;
    logic [TS_WIDTH-1:0] s0;
    logic [TS_WIDTH-1:0] s1;
    logic                deliver;
    logic                forced;
    logic [7:0]          req_ext;
    logic [7:0]          onehot;

    assign req_ext = {{(8-NREQ){1'b0}}, REQ};
    assign onehot  = 8'(1) << idx;
    assign BUSY    = (state != IDLE);

    // Search starts just after the last served requester so every builder gets a turn.
    always_comb begin
        pick       = '0;
        cand       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 3'((int'(rr_ptr) + i) % NREQ);
            if (!pick_found && req_ext[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        deliver    = 1'b0;
        forced     = 1'b0;
        case (state)
            IDLE:  if (pick_found) next_state = SMP_A;
            SMP_A: next_state = SMP_B;
            SMP_B: next_state = CMP;
            CMP: begin
                if (s0 == s1) begin
                    deliver    = 1'b1;
                    next_state = IDLE;
                end else if (retry < 4'(MAX_RETRY)) begin
                    next_state = SMP_A;
                end else begin
                    deliver    = 1'b1;
                    forced     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            idx          <= '0;
            rr_ptr       <= 3'(NREQ - 1);
            retry        <= '0;
            s0           <= '0;
            s1           <= '0;
            GRANT        <= '0;
            TS_OUT       <= '0;
            TS_VALID     <= 1'b0;
            TS_SRC       <= '0;
            ERR_UNSTABLE <= 1'b0;
        end else begin
            state    <= next_state;
            TS_VALID <= deliver;
            GRANT    <= deliver ? onehot[NREQ-1:0] : '0;
            if (state == IDLE && pick_found) idx <= pick;
            if (state == SMP_A) s0 <= TIMESTAMP;
            if (state == SMP_B) s1 <= TIMESTAMP;
            if (state == CMP && !deliver) retry <= retry + 4'd1;
            if (deliver) begin
                TS_OUT <= s1;
                TS_SRC <= idx;
                rr_ptr <= idx;
                retry  <= '0;
                if (forced) ERR_UNSTABLE <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timestamp_arbiter.sv
// tb/tb_timestamp_arbiter.sv - randomized bench for timestamp_arbiter against a transaction-level model
module tb_timestamp_arbiter;

    localparam int N = 4000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [23:0] TIMESTAMP = '0;
    logic [3:0]  REQ = '0;
    logic [3:0]  GRANT;
    logic [23:0] TS_OUT;
    logic        TS_VALID;
    logic [2:0]  TS_SRC;
    logic        BUSY;
    logic        ERR_UNSTABLE;

    timestamp_arbiter #(.NREQ(4), .TS_WIDTH(24), .MAX_RETRY(7)) dut (
        .CLK(CLK), .RESET(RESET), .TIMESTAMP(TIMESTAMP), .REQ(REQ),
        .GRANT(GRANT), .TS_OUT(TS_OUT), .TS_VALID(TS_VALID), .TS_SRC(TS_SRC),
        .BUSY(BUSY), .ERR_UNSTABLE(ERR_UNSTABLE)
    );

    always #5 CLK = ~CLK;

    logic        rst_a [N];
    logic [3:0]  req_a [N];
    logic [23:0] ts_a  [N];
    logic        ev    [N];
    logic [3:0]  eg    [N];
    logic [23:0] ets   [N];
    logic [2:0]  esrc  [N];
    logic        eb    [N];
    logic        eerr  [N];

    int          m_rr;
    logic [23:0] m_ts;
    logic [2:0]  m_src;
    logic        m_err;
    int          checks = 0;
    int          errors = 0;

    task automatic put(input int e, input logic v, input logic [3:0] g, input logic b);
        ev[e] = v; eg[e] = g; ets[e] = m_ts; esrc[e] = m_src; eb[e] = b; eerr[e] = m_err;
    endtask

    task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    // Each request is one transaction: pick by round robin, then 3-edge sample/compare attempts.
    task automatic build_model();
        int e;
        int idx;
        int r;
        int step;
        bit found;
        bit done;
        logic [23:0] s0;
        logic [23:0] s1;
        e = 0; m_rr = 3; m_ts = '0; m_src = '0; m_err = 1'b0;
        s0 = '0; s1 = '0;
        while (e < N) begin
            if (rst_a[e]) begin
                m_rr = 3; m_ts = '0; m_src = '0; m_err = 1'b0;
                put(e, 1'b0, 4'b0, 1'b0);
                e++;
                continue;
            end
            if (req_a[e] == 4'b0) begin
                put(e, 1'b0, 4'b0, 1'b0);
                e++;
                continue;
            end
            found = 1'b0; idx = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req_a[e][(m_rr + k) % 4]) begin
                    idx = (m_rr + k) % 4;
                    found = 1'b1;
                end
            end
            put(e, 1'b0, 4'b0, 1'b1);
            e++;
            r = 0; step = 0; done = 1'b0;
            while (e < N && !rst_a[e] && !done) begin
                if (step == 0) begin
                    s0 = ts_a[e];
                    put(e, 1'b0, 4'b0, 1'b1);
                end else if (step == 1) begin
                    s1 = ts_a[e];
                    put(e, 1'b0, 4'b0, 1'b1);
                end else if (s0 == s1 || r == 7) begin
                    m_ts = s1; m_src = 3'(idx); m_rr = idx;
                    if (s0 != s1) m_err = 1'b1;
                    put(e, 1'b1, 4'(1 << idx), 1'b0);
                    done = 1'b1;
                end else begin
                    r++;
                    put(e, 1'b0, 4'b0, 1'b1);
                end
                step = (step + 1) % 3;
                e++;
            end
        end
    endtask

    task automatic build_stimulus();
        int mode;
        logic [23:0] t;
        logic [3:0] rq;
        for (int e = 0; e < N; e++) begin
            rst_a[e] = 1'b0; req_a[e] = 4'b0; ts_a[e] = 24'h555555;
        end
        rst_a[0] = 1'b1; rst_a[1] = 1'b1; req_a[0] = 4'b1111; req_a[1] = 4'b1111;
        for (int e = 0; e < 30; e++) ts_a[e] = 24'h001234;
        for (int e = 2; e <= 5; e++) req_a[e] = 4'b0100;
        rst_a[7] = 1'b1; rst_a[8] = 1'b1;
        for (int e = 9; e <= 28; e++) req_a[e] = 4'b1111;
        ts_a[30] = 24'h0000FF; ts_a[31] = 24'h0000FF;
        for (int e = 32; e < 38; e++) ts_a[e] = 24'h000100;
        for (int e = 30; e <= 36; e++) req_a[e] = 4'b0010;
        for (int e = 38; e <= 62; e++) begin
            ts_a[e] = 24'hABC000 + 24'(e);
            req_a[e] = 4'b0010;
        end
        for (int e = 64; e <= 67; e++) req_a[e] = 4'b0001;
        for (int e = 69; e <= 70; e++) req_a[e] = 4'b1000;
        rst_a[71] = 1'b1; req_a[71] = 4'b1000;
        for (int e = 72; e < 80; e++) req_a[e] = 4'b1001;
        mode = 0; t = 24'hFFFFF0; rq = 4'b0;
        for (int e = 80; e < N; e++) begin
            if (e % 250 == 0) mode = int'($urandom_range(0, 2));
            if (e % 1000 == 0) t = 24'hFFFFFA;
            case (mode)
                0: if ($urandom_range(0, 49) == 0) t = t + 24'd1;
                1: t = t + 24'd1;
                default: if ($urandom_range(0, 3) == 0) t = t + 24'd1;
            endcase
            ts_a[e] = t;
            rst_a[e] = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
            req_a[e] = rq;
        end
    endtask

    initial begin
        build_stimulus();
        build_model();

        chk("lit_reset_grant", 0, 32'(eg[0]), 32'h0);
        chk("lit_reset_busy", 1, 32'(eb[1]), 32'h0);
        chk("lit_t2_valid", 5, 32'(ev[5]), 32'h1);
        chk("lit_t2_ts", 5, 32'(ets[5]), 32'h001234);
        chk("lit_t2_src", 5, 32'(esrc[5]), 32'h2);
        chk("lit_t2_grant", 5, 32'(eg[5]), 32'h4);
        chk("lit_t3_g0", 12, 32'(eg[12]), 32'h1);
        chk("lit_t3_g1", 16, 32'(eg[16]), 32'h2);
        chk("lit_t3_g2", 20, 32'(eg[20]), 32'h4);
        chk("lit_t3_g3", 24, 32'(eg[24]), 32'h8);
        chk("lit_t3_g4", 28, 32'(eg[28]), 32'h1);
        chk("lit_t4_no_early", 33, 32'(ev[33]), 32'h0);
        chk("lit_t4_ts", 36, 32'(ets[36]), 32'h000100);
        chk("lit_t4_err", 36, 32'(eerr[36]), 32'h0);
        chk("lit_t5_ts", 62, 32'(ets[62]), 32'hABC03D);
        chk("lit_t5_err", 62, 32'(eerr[62]), 32'h1);
        chk("lit_t5_sticky", 67, 32'(eerr[67] & ev[67]), 32'h1);
        chk("lit_t6_err_cleared", 71, 32'(eerr[71]), 32'h0);
        chk("lit_t6_no_valid", 74, 32'(ev[74]), 32'h0);
        chk("lit_t6_first", 75, 32'(eg[75]), 32'h1);
        chk("lit_t6_second", 79, 32'(eg[79]), 32'h8);

        for (int e = 0; e < N; e++) begin
            @(negedge CLK);
            RESET = rst_a[e];
            REQ = req_a[e];
            TIMESTAMP = ts_a[e];
            @(posedge CLK);
            #1;
            chk("ts_valid", e, 32'(TS_VALID), 32'(ev[e]));
            chk("grant", e, 32'(GRANT), 32'(eg[e]));
            chk("ts_out", e, 32'(TS_OUT), 32'(ets[e]));
            chk("ts_src", e, 32'(TS_SRC), 32'(esrc[e]));
            chk("busy", e, 32'(BUSY), 32'(eb[e]));
            chk("err_unstable", e, 32'(ERR_UNSTABLE), 32'(eerr[e]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
